// File: rtl/lbus_master.sv
// lbus_master: SURF local-bus initiator turning client bursts into nADS/nRD/nWR bus cycles
module lbus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_space_i,
  input  logic [5:0]  req_addr_i,
  input  logic [3:0]  req_len_i,
  input  logic [31:0] wr_dat_i,
  output logic        wr_next_o,
  output logic [31:0] rd_dat_o,
  output logic        rd_vld_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        nADS,
  output logic        WnR,
  output logic        nCS2,
  output logic        nCS3,
  output logic        nRD,
  output logic        nWR,
  output logic [5:0]  LA,
  inout  wire  [31:0] LD,
  input  logic        nREADY,
  input  logic        nBTERM
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RECOVER} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic        wr_q, wr_d, err_q, err_d, rd_vld_q, rd_vld_d;
  logic [1:0]  space_q, space_d;
  logic [5:0]  la_q, la_d;
  logic [4:0]  beats_q, beats_d;
  logic [7:0]  to_q, to_d;
  logic [31:0] ld_q, ld_d, rd_dat_q, rd_dat_d;
  logic        cyc;
  assign cyc       = state_q == ADDR || state_q == DATA;
  assign nADS      = state_q != ADDR;
  assign WnR       = cyc && wr_q;
  assign nCS2      = !(cyc && space_q == 2'd1);
  assign nCS3      = !(cyc && space_q == 2'd2);
  assign nRD       = !(state_q == DATA && !wr_q);
  assign nWR       = !(state_q == DATA && wr_q);
  assign LA        = la_q;
  assign LD        = (state_q == DATA && wr_q) ? ld_q : 'z;
  assign busy_o    = state_q != IDLE;
  assign done_o    = state_q == RECOVER;
  assign err_o     = done_o && err_q;
  assign rd_dat_o  = rd_dat_q;
  assign rd_vld_o  = rd_vld_q;
  // next state: accept, address phase, beat completion / re-arbitration / timeout, recovery
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    space_d   = space_q;
    la_d      = la_q;
    beats_d   = beats_q;
    ld_d      = ld_q;
    to_d      = to_q;
    err_d     = err_q;
    rd_dat_d  = rd_dat_q;
    rd_vld_d  = 1'b0;
    wr_next_o = 1'b0;
    case (state_q)
      IDLE: if (req_i) begin
        wr_d      = req_wr_i;
        space_d   = req_space_i;
        la_d      = req_addr_i;
        beats_d   = {1'b0, req_len_i} + 5'd1;
        to_d      = '0;
        err_d     = 1'b0;
        ld_d      = req_wr_i ? wr_dat_i : ld_q;
        wr_next_o = req_wr_i;
        state_d   = ADDR;
      end
      ADDR: state_d = DATA;
      DATA: if (!nREADY) begin
        la_d      = la_q + 6'd1;
        beats_d   = beats_q - 5'd1;
        to_d      = '0;
        rd_dat_d  = wr_q ? rd_dat_q : LD;
        rd_vld_d  = !wr_q;
        wr_next_o = wr_q && beats_q != 5'd1;
        ld_d      = (wr_q && beats_q != 5'd1) ? wr_dat_i : ld_q;
        state_d   = beats_q == 5'd1 ? RECOVER : !nBTERM ? ADDR : DATA;
      end else if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = RECOVER;
      end else begin
        to_d = to_q + 8'd1;
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      space_q  <= '0;
      la_q     <= '0;
      beats_q  <= '0;
      ld_q     <= '0;
      to_q     <= '0;
      err_q    <= 1'b0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      space_q  <= space_d;
      la_q     <= la_d;
      beats_q  <= beats_d;
      ld_q     <= ld_d;
      to_q     <= to_d;
      err_q    <= err_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
    end
  end
endmodule

// File: tb/tb_lbus_master.sv
// tb_lbus_master: directed table plus random bursts against a SURF slave and memory model
module tb_lbus_master;
  localparam int TMO = 16;
  logic        clk = 0, nrst = 0, req = 0, req_wr = 0;
  logic [1:0]  req_space = 0;
  logic [5:0]  req_addr = 0;
  logic [3:0]  req_len = 0;
  logic [31:0] wr_dat;
  logic        wr_next, rd_vld, busy, done, err;
  logic [31:0] rd_dat;
  logic        nADS, WnR, nCS2, nCS3, nRD, nWR;
  logic [5:0]  LA;
  wire  [31:0] LD;
  logic        nREADY = 1, nBTERM = 1;

  lbus_master #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .nrst_i(nrst), .req_i(req), .req_wr_i(req_wr), .req_space_i(req_space),
    .req_addr_i(req_addr), .req_len_i(req_len), .wr_dat_i(wr_dat), .wr_next_o(wr_next),
    .rd_dat_o(rd_dat), .rd_vld_o(rd_vld), .busy_o(busy), .done_o(done), .err_o(err),
    .nADS(nADS), .WnR(WnR), .nCS2(nCS2), .nCS3(nCS3), .nRD(nRD), .nWR(nWR), .LA(LA),
    .LD(LD), .nREADY(nREADY), .nBTERM(nBTERM)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [1:0] sp, input logic [5:0] a);
    return (sp == 0 && a == 0) ? 32'h53555246 : (32'hC0DE0000 | {22'd0, sp, 2'b00, a});
  endfunction

  // SURF slave: memory per chip-select space, ready after s_lat wait cycles
  logic [31:0] smem [3][64];
  bit          svld [3][64] = '{default: 0};
  logic [1:0]  s_sp = 0;
  logic [5:0]  s_a = 0;
  int          s_w = 0, s_lat = 0;
  bit          s_dead = 0;
  assign LD = !nRD ? (svld[s_sp][s_a] ? smem[s_sp][s_a] : dflt(s_sp, s_a)) : 'z;

  always @(negedge clk) begin
    int w;
    if (!nRD || !nWR) begin
      w = (nREADY == 0) ? 0 : s_w;
      nREADY <= (s_dead || w < s_lat);
      s_w <= w + 1;
    end else begin
      nREADY <= 1;
      s_w <= 0;
    end
  end

  always @(posedge clk) begin
    if (!nADS) begin
      s_sp <= !nCS2 ? 2'd1 : !nCS3 ? 2'd2 : 2'd0;
      s_a  <= LA;
    end else if ((!nRD || !nWR) && !nREADY) begin
      if (!nWR) begin
        smem[s_sp][s_a] <= LD;
        svld[s_sp][s_a] <= 1;
      end
      s_a <= s_a + 1;
    end
  end

  // write-data source and observation of the bus
  logic [31:0] wbuf [256];
  int          pop_n = 0, cyc = 0, ads_n = 0, done_n = 0;
  logic [31:0] got_rd[$];
  int          got_rdc[$];
  logic [7:0]  la_log[$];
  assign wr_dat = wbuf[pop_n[7:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_next) pop_n <= pop_n + 1;
  end
  always @(negedge clk) begin
    if (!nADS) begin
      ads_n++;
      la_log.push_back({(!nCS2 ? 2'd1 : !nCS3 ? 2'd2 : 2'd0), LA});
    end
    if (rd_vld) begin
      got_rd.push_back(rd_dat);
      got_rdc.push_back(cyc);
    end
    if (done) done_n++;
  end

  int ncmp = 0, nfail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit wr; bit [1:0] sp; bit [5:0] a; bit [3:0] len; int lat;
    bit burst, dead, hold, chk; bit [31:0] d; bit eerr; int eads;
  } vec_t;

  bit [31:0] mm [3][64];

  task automatic run(input vec_t v);
    int beats = v.len + 1, msp = (v.sp == 3) ? 0 : v.sp, n = 0, nla;
    int a0 = ads_n, r0 = got_rd.size(), l0 = la_log.size(), p0 = pop_n, d0 = done_n;
    bit seen = 0, gerr = 0;
    logic [5:0] ctl = 0;
    logic [31:0] er[$];
    for (int i = 0; i < beats; i++) begin
      if (v.wr) begin
        wbuf[(p0 + i) & 255] = (i == 0 && v.chk) ? v.d : $urandom;
        if (!v.dead) mm[msp][(v.a + i) & 63] = wbuf[(p0 + i) & 255];
      end else er.push_back(mm[msp][(v.a + i) & 63]);
    end
    s_lat = v.lat; s_dead = v.dead; nBTERM = v.burst;
    @(negedge clk); #1;
    req = 1; req_wr = v.wr; req_space = v.sp; req_addr = v.a; req_len = v.len;
    @(posedge clk);
    while (n < 600) begin
      @(negedge clk); #1;
      n++;
      if (!v.hold) req = 0;
      if (n == 1) chk("busy_after_accept", busy, 1);
      if (done) begin
        seen = 1; gerr = err; ctl = {nADS, nCS2, nCS3, nRD, nWR, WnR};
        req = 0;
        break;
      end
    end
    if (!seen) chk("done_bound", 0, 1);
    chk("err", gerr, v.eerr);
    chk("latency", n, v.dead ? TMO + 2 : 2 + beats * (v.lat + 1) + (v.burst ? 0 : beats - 1));
    chk("ctl_recover", ctl, 6'b111110);
    @(negedge clk); #1;
    chk("busy_idle", busy, 0);
    @(negedge clk); #1;
    chk("done_pulses", done_n - d0, 1);
    chk("nads_pulses", ads_n - a0, v.eads);
    chk("pops", pop_n - p0, v.wr ? (v.dead ? 1 : beats) : 0);
    chk("rd_vld_count", got_rd.size() - r0, (v.wr || v.dead) ? 0 : beats);
    if (!v.wr && !v.dead && got_rd.size() - r0 == beats) begin
      for (int i = 0; i < beats; i++) chk("rd_data", got_rd[r0 + i], er[i]);
      if (v.chk) chk("rd_data_const", got_rd[r0], v.d);
      if (v.lat == 0 && v.burst) chk("rd_stream", got_rdc[r0 + beats - 1] - got_rdc[r0], beats - 1);
    end
    nla = (v.burst || v.dead) ? 1 : beats;
    if (la_log.size() - l0 == nla)
      for (int i = 0; i < nla; i++) chk("la_cs", la_log[l0 + i], {msp[1:0], 6'((v.a + i) & 63)});
  endtask

  vec_t tv[10];
  vec_t rv;
  initial begin
    for (int s = 0; s < 3; s++) for (int a = 0; a < 64; a++) mm[s][a] = dflt(2'(s), 6'(a));
    for (int i = 0; i < 256; i++) wbuf[i] = 0;
    tv[0] = '{0, 0, 6'h00, 0, 1, 1, 0, 0, 1, 32'h53555246, 0, 1};
    tv[1] = '{1, 0, 6'h07, 0, 2, 1, 0, 0, 1, 32'hA5A50F0F, 0, 1};
    tv[2] = '{0, 0, 6'h07, 0, 0, 1, 0, 0, 1, 32'hA5A50F0F, 0, 1};
    tv[3] = '{0, 2, 6'h3E, 3, 0, 1, 0, 1, 0, 32'h0, 0, 1};
    tv[4] = '{0, 2, 6'h3E, 3, 0, 0, 0, 0, 0, 32'h0, 0, 4};
    tv[5] = '{0, 0, 6'h00, 1, 0, 1, 1, 0, 0, 32'h0, 1, 1};
    tv[6] = '{1, 1, 6'h3C, 5, 0, 0, 0, 0, 0, 32'h0, 0, 6};
    tv[7] = '{0, 1, 6'h3C, 5, 1, 1, 0, 0, 0, 32'h0, 0, 1};
    tv[8] = '{0, 3, 6'h07, 0, 0, 0, 0, 0, 1, 32'hA5A50F0F, 0, 1};
    tv[9] = '{1, 2, 6'h10, 2, 0, 1, 1, 0, 0, 32'h0, 1, 1};
    repeat (2) @(negedge clk);
    chk("rst_ctl", {nADS, nCS2, nCS3, nRD, nWR, WnR}, 6'b111110);
    chk("rst_out", {busy, done, err, rd_vld, wr_next, LA, rd_dat}, 0);
    nrst = 1;
    for (int i = 0; i < 10; i++) run(tv[i]);
    // reset in the middle of a streaming LAB burst
    s_lat = 0; s_dead = 0; nBTERM = 1;
    @(negedge clk); #1;
    req = 1; req_wr = 0; req_space = 2; req_addr = 6'h05; req_len = 15;
    @(posedge clk);
    @(negedge clk); #1;
    req = 0;
    repeat (3) @(negedge clk);
    #2 nrst = 0;
    #1;
    chk("midrst_ctl", {nADS, nCS2, nCS3, nRD, nWR, WnR}, 6'b111110);
    chk("midrst_out", {busy, done, err, rd_vld, wr_next, LA, rd_dat}, 0);
    @(negedge clk); #1;
    nrst = 1;
    run(tv[3]);
    for (int k = 0; k < 40; k++) begin
      rv.wr = 1'($urandom); rv.sp = 2'($urandom); rv.a = 6'($urandom); rv.len = 4'($urandom);
      rv.lat = $urandom_range(0, 2); rv.burst = 1'($urandom); rv.dead = ($urandom_range(0, 7) == 0);
      rv.hold = 1'($urandom); rv.chk = 0; rv.d = 0; rv.eerr = rv.dead;
      rv.eads = (rv.burst || rv.dead) ? 1 : rv.len + 1;
      run(rv);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
